// File: rtl/la_pkg.sv
// Shared types and constants for the logic analyzer capture/dump engine.
package la_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_POST = 3'd2,
        S_DONE = 3'd3,
        S_DRD  = 3'd4,
        S_DVLD = 3'd5
    } cap_state_t;

endpackage

// File: rtl/la_capture_engine_if.sv
// Bus between the capture engine, the sample/trigger front end, the RAM queue and the host path.
interface la_capture_engine_if #(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
);
    localparam int DW = NUM_CH * la_pkg::BYTE_W;

    logic                       wrt_smpl;
    logic [DW-1:0]              smpl_data;
    logic                       trig;
    logic                       arm;
    logic [LOG2-1:0]            trig_pos;
    logic                       dump_req;
    logic [2:0]                 dump_ch;
    logic                       dump_rdy;
    logic                       we;
    logic [LOG2-1:0]            waddr;
    logic [LOG2-1:0]            raddr;
    logic [DW-1:0]              rdata;
    logic                       triggered;
    logic                       capture_done;
    logic [la_pkg::BYTE_W-1:0]  dump_data;
    logic                       dump_vld;
    logic                       dump_last;
    logic                       busy;

    // Dump handshake: once dump_vld rises, dump_data and dump_last stay stable until a
    // cycle with dump_vld && dump_rdy, which transfers the byte; dump_rdy never feeds vld.
    modport master (
        input  wrt_smpl, smpl_data, trig, arm, trig_pos, dump_req, dump_ch, dump_rdy, rdata,
        output we, waddr, raddr, triggered, capture_done, dump_data, dump_vld, dump_last, busy
    );

    modport slave (
        output wrt_smpl, smpl_data, trig, arm, trig_pos, dump_req, dump_ch, dump_rdy, rdata,
        input  we, waddr, raddr, triggered, capture_done, dump_data, dump_vld, dump_last, busy
    );

endinterface

// File: rtl/la_wrap_ctr.sv
// Modulo-ENTRIES address counter with clear, load and increment.
module la_wrap_ctr #(
    parameter int LOG2    = 9,
    parameter int ENTRIES = 384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_ld,
    input  logic [LOG2-1:0] i_ld_val,
    input  logic            i_inc,
    output logic [LOG2-1:0] o_cnt
);
    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

    logic [LOG2-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + LOG2'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/la_capture_engine.sv
// Circular-buffer capture with programmable post-trigger length, and single-channel
// oldest-first dump over a valid/ready handshake.
module la_capture_engine
    import la_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic                clk,
    input  logic                rst,
    la_capture_engine_if.master bus,
    output cap_state_t          o_dbg_state
);
    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

    cap_state_t        r_state, w_next;
    logic [LOG2-1:0]   r_tp, r_pre_cnt, r_post_cnt, r_byte_cnt;
    logic              r_armed, r_triggered, r_capture_done;
    logic [2:0]        r_dump_ch;
    logic [BYTE_W-1:0] r_dump_data;
    logic              r_dump_vld, r_dump_last;

    logic              w_we, w_trig_acc, w_post_wr, w_post_hit, w_hs, w_last_byte;
    logic              w_start_cap, w_start_dump;
    logic [LOG2-1:0]   w_tp_in, w_pre_target, w_pre_nxt, w_post_nxt, w_waddr, w_raddr;
    logic [BYTE_W-1:0] w_sel_byte;

    // A zero post-trigger count still needs the trigger sample itself stored.
    always_comb begin
        w_tp_in = bus.trig_pos;
        if (bus.trig_pos == '0) begin
            w_tp_in = LOG2'(1);
        end else if (int'(bus.trig_pos) >= ENTRIES) begin
            w_tp_in = LAST_IDX;
        end
    end

    assign w_pre_target = LOG2'(ENTRIES - int'(r_tp));
    assign w_pre_nxt    = r_pre_cnt + LOG2'(1);
    assign w_we         = bus.wrt_smpl && (r_state == S_PRE || r_state == S_POST);
    assign w_trig_acc   = (r_state == S_PRE) && r_armed && bus.wrt_smpl && bus.trig;
    assign w_post_wr    = w_trig_acc || (r_state == S_POST && w_we);
    assign w_post_nxt   = w_trig_acc ? LOG2'(1) : r_post_cnt + LOG2'(1);
    assign w_post_hit   = w_post_wr && (w_post_nxt == r_tp);
    assign w_hs         = (r_state == S_DVLD) && r_dump_vld && bus.dump_rdy;
    assign w_last_byte  = (r_byte_cnt == LAST_IDX);

    always_comb begin
        w_sel_byte = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_dump_ch == 3'(k)) begin
                w_sel_byte = bus.rdata[k*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_start_cap  = 1'b0;
        w_start_dump = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.arm) begin
                    w_next      = S_PRE;
                    w_start_cap = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.arm) begin
                    w_next      = S_PRE;
                    w_start_cap = 1'b1;
                end else if (bus.dump_req) begin
                    w_next       = S_DRD;
                    w_start_dump = 1'b1;
                end
            end
            S_PRE:  if (w_trig_acc) w_next = w_post_hit ? S_DONE : S_POST;
            S_POST: if (w_post_hit) w_next = S_DONE;
            S_DRD:  w_next = S_DVLD;
            S_DVLD: if (w_hs) w_next = w_last_byte ? S_DONE : S_DRD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tp           <= '0;
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_armed        <= 1'b0;
            r_triggered    <= 1'b0;
            r_capture_done <= 1'b0;
            r_dump_ch      <= '0;
            r_byte_cnt     <= '0;
            r_dump_data    <= '0;
            r_dump_vld     <= 1'b0;
            r_dump_last    <= 1'b0;
        end else begin
            if (w_start_cap) begin
                r_tp           <= w_tp_in;
                r_pre_cnt      <= '0;
                r_post_cnt     <= '0;
                r_armed        <= 1'b0;
                r_triggered    <= 1'b0;
                r_capture_done <= 1'b0;
            end
            // pre_cnt stops once armed, so it saturates at the pre-fill target
            if (r_state == S_PRE && w_we && !r_armed) begin
                r_pre_cnt <= w_pre_nxt;
                r_armed   <= (w_pre_nxt == w_pre_target);
            end
            if (w_trig_acc) r_triggered <= 1'b1;
            if (w_post_wr) r_post_cnt <= w_post_nxt;
            if (w_post_hit) r_capture_done <= 1'b1;
            if (w_start_dump) begin
                r_dump_ch  <= bus.dump_ch;
                r_byte_cnt <= '0;
            end
            // rdata is valid in the first DVLD cycle; capture it once and hold under backpressure
            if (r_state == S_DVLD && !r_dump_vld) begin
                r_dump_data <= w_sel_byte;
                r_dump_vld  <= 1'b1;
                r_dump_last <= w_last_byte;
            end else if (w_hs) begin
                r_dump_vld  <= 1'b0;
                r_dump_last <= 1'b0;
                r_byte_cnt  <= r_byte_cnt + LOG2'(1);
            end
        end
    end

    la_wrap_ctr #(.LOG2(LOG2), .ENTRIES(ENTRIES)) u_waddr (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_cap),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_inc    (w_we),
        .o_cnt    (w_waddr)
    );

    // At DONE the write pointer sits on the oldest entry, which is where a dump starts.
    la_wrap_ctr #(.LOG2(LOG2), .ENTRIES(ENTRIES)) u_raddr (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (1'b0),
        .i_ld     (w_start_dump),
        .i_ld_val (w_waddr),
        .i_inc    (w_hs && !w_last_byte),
        .o_cnt    (w_raddr)
    );

    assign bus.we           = w_we;
    assign bus.waddr        = w_waddr;
    assign bus.raddr        = w_raddr;
    assign bus.triggered    = r_triggered;
    assign bus.capture_done = r_capture_done;
    assign bus.dump_data    = r_dump_data;
    assign bus.dump_vld     = r_dump_vld;
    assign bus.dump_last    = r_dump_last;
    assign bus.busy         = (r_state == S_PRE) || (r_state == S_POST) ||
                              (r_state == S_DRD) || (r_state == S_DVLD);
    assign o_dbg_state      = r_state;

endmodule
